// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch buffer: fetch FSM states and the
// {pc, instr} entry carried through the FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is an unregistered read
// of the oldest entry. DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Flush wins over push/pop; overflow and underflow requests are dropped.
  assign w_do_push = i_push & ~i_flush & (r_count != FULL_COUNT);
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != {CW{1'b0}});

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Prefetch buffer: issues sequential word fetches (one outstanding), queues
// {pc, instr} responses and kills wrong-path fetches on redirect.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_START_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH            = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  logic          w_space;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_in_flight;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // A kept in-flight fetch reserves a slot; a same-cycle pop is not credited.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, (r_state == FETCH_WAIT)};
  assign w_space     = w_occupancy < DEPTH_W;
  assign w_in_flight = (r_state == FETCH_WAIT) | (r_state == FETCH_DROP);

  assign mem_req_valid = ~rst & ena & ~redirect & w_space &
                         ((r_state == FETCH_IDLE) | (w_in_flight & mem_rsp_valid));
  assign mem_req_addr  = r_fetch_pc;
  assign w_accept      = mem_req_valid & mem_req_ready;

  assign w_push      = (r_state == FETCH_WAIT) & mem_rsp_valid & ~redirect;
  assign w_push_data = '{pc: r_req_pc, instr: mem_rsp_data};
  assign if_valid    = (w_count != {CW{1'b0}}) & ~redirect;
  assign w_pop       = if_valid & if_ready;
  assign if_pc       = w_head.pc;
  assign if_instr    = w_head.instr;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_push_data),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch FSM next state; a redirect turns a still-pending fetch into a drop.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      case (r_state)
        FETCH_WAIT, FETCH_DROP: w_state_nxt = mem_rsp_valid ? FETCH_IDLE : FETCH_DROP;
        default:                w_state_nxt = FETCH_IDLE;
      endcase
    end else begin
      case (r_state)
        FETCH_IDLE: w_state_nxt = w_accept ? FETCH_WAIT : FETCH_IDLE;
        FETCH_WAIT, FETCH_DROP: begin
          if (mem_rsp_valid) w_state_nxt = w_accept ? FETCH_WAIT : FETCH_IDLE;
          else               w_state_nxt = r_state;
        end
        default:    w_state_nxt = FETCH_IDLE;
      endcase
    end
  end

  // State, next fetch address and address of the outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= PC_START_ADDRESS;
      r_req_pc   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)      r_fetch_pc <= word_align(redirect_pc);
      else if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_accept) r_req_pc <= r_fetch_pc;
    end
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction prefetch buffer between the pipelined RV32I core's fetch stage and a variable-latency instruction memory. It issues sequential word fetches ahead of the core and queues returned {pc, instr} pairs in a small FIFO. It presents them to the fetch stage with a valid/ready handshake and discards wrong-path fetches on a branch/jump redirect from execute.

## Interface
- PC_START_ADDRESS, 0: first fetch address after reset; must be word aligned.
- DEPTH, 4: FIFO entries (power of two, ≥2); also caps buffered plus in-flight fetches.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  when low, no new memory request is issued; FIFO, redirect and response capture keep working.
- mem_req_valid  out  1  fetch request.
- mem_req_ready  in  1  request accepted when valid & ready.
- mem_req_addr  out  32  word address (bits [1:0] = 0).
- mem_rsp_valid  in  1  response strobe; in order, ≥1 cycle after acceptance.
- mem_rsp_data  in  32  instruction word.
- if_valid  out  1  head entry available.
- if_ready  in  1  core consumes head when if_valid & if_ready (low = stall_f).
- if_pc  out  32  PC of head entry.
- if_instr  out  32  instruction of head entry.
- redirect  in  1  taken branch/jump in execute (pc_src_e).
- redirect_pc  in  32  new fetch PC (pc_target_e); bits [1:0] ignored.

## Operation
- Registers: fetch_pc (next address), req_pc (PC of in-flight request), state, and the FIFO.
- States: FETCH_IDLE (nothing in flight), FETCH_WAIT (one request in flight, response kept), FETCH_DROP (one in flight, response discarded). At most one request is outstanding.
- mem_req_valid = !rst & ena & !redirect & space & (IDLE | ((WAIT | DROP) & mem_rsp_valid)), where space = count + (state==WAIT) < DEPTH. It does not count a same-cycle pop (conservative).
- Requests may be withdrawn. The address is not required to stay stable while unaccepted.
- mem_req_addr = fetch_pc. On acceptance: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32), state <= WAIT.
- Response in WAIT without redirect: push {req_pc, mem_rsp_data}. State → IDLE, or stays WAIT if a new request is accepted the same cycle.
- Response in DROP: discarded. State → IDLE, or → WAIT if a new request is accepted the same cycle.
- Redirect (highest priority):
  - FIFO flushed (count <= 0); any same-cycle push and pop are suppressed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - WAIT → DROP if !mem_rsp_valid, else IDLE (response dropped). DROP → DROP/IDLE likewise. IDLE stays IDLE.
- if_valid = (count != 0) & !redirect. if_pc/if_instr show the head entry, unregistered FIFO read.
- Push and pop in the same cycle with count == DEPTH is impossible by the space rule. With 0 < count < DEPTH, both happen and count is unchanged.

## Timing
- Reset values: mem_req_valid 0, if_valid 0, fetch_pc = PC_START_ADDRESS, state IDLE, count 0. if_pc/if_instr are don't-care while if_valid = 0.
- First request is asserted in the first cycle with rst low.
- Request accepted at cycle t, response at t+L (L≥1), entry visible on if_valid at t+L+1. There is no response-to-output bypass.
- With L = 1 and ready always high, a new request issues on every response cycle, giving one instruction per cycle in steady state.
- After a redirect at cycle r with mem_req_ready high: request to redirect_pc at r+1 (if IDLE), if_valid at r+3 for L = 1.
- When if_ready is held low the FIFO fills to DEPTH, then mem_req_valid deasserts. There is no overflow and no lost response.
- rst mid-flight: state → IDLE, and any later response to the killed request is ignored. The memory must drop it or reset with the buffer.

## Structure
- Shared package (fetch_pkg): fetch_state_t enum {FETCH_IDLE, FETCH_WAIT, FETCH_DROP}; fetch_entry_t packed struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH entries, push/pop/flush, count, head output, and wrapping pointers.

## Test plan
- Reset with PC_START_ADDRESS=0x100, mem ready=1, L=1, if_ready=1 → requests 0x100, 0x104, 0x108 on consecutive cycles; if_pc 0x100 valid 2 cycles after the first request, then one entry per cycle.
- if_ready=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered (0x100–0x10C), mem_req_valid low; after release, 0x110 is requested and entries drain in order.
- Redirect to 0x200 while a request for 0x108 is in flight (L=3) → 0x108 response discarded, FIFO empty, next request 0x200, if_pc 0x200 is the next valid entry.
- Redirect in the same cycle as a pop and a response → nothing pushed, pop ignored, count 0; redirect_pc 0x203 → request address 0x200.
- ena=0 while IDLE for 5 cycles → no requests, buffered entries still drain; ena=1 → fetch resumes at the held fetch_pc.
- Random mem_req_ready/L (1–4) and if_ready against a reference PC model → delivered if_pc sequence is strictly sequential between redirects with no duplicates or gaps.
